// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_pkg
// Description : Shared types and address-field width helpers for the
//               set-associative data cache.
//               state_t  - controller states (IDLE, WB, FILL)
//               word_w   - word-select field width inside a line
//               index_w  - set-index field width
//               tag_w    - tag field width
//               way_w    - way-number width (at least 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    // Two low address bits select the byte inside a word.
    localparam int c_BYTE_W = 2;

    function automatic int word_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - c_BYTE_W - word_w(line_words) - index_w(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru
// Description : Per-set age ranks for true-LRU replacement. Rank 0 is the
//               most recently used way, rank WAYS-1 the least recent.
//   clk       in   clock
//   rst       in   synchronous active-high reset (rank = way number)
//   set_idx   in   set being looked up / touched
//   touch_way in   way that was just used
//   touch_en  in   promote touch_way to rank 0 at the clock edge
//   victim    out  least recently used way of set_idx
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru
    import data_cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [index_w(SETS)-1:0]  set_idx,
    input  logic [way_w(WAYS)-1:0]    touch_way,
    input  logic                      touch_en,
    output logic [way_w(WAYS)-1:0]    victim
);

    localparam int c_WAY_W = way_w(WAYS);
    localparam logic [c_WAY_W-1:0] c_LAST_RANK = c_WAY_W'(WAYS - 1);

    logic [c_WAY_W-1:0] r_rank [SETS][WAYS];
    logic [c_WAY_W-1:0] w_touch_rank;

    assign w_touch_rank = r_rank[set_idx][touch_way];

    // Ways younger than the touched one age by one; older ways keep their
    // rank, so the ranks of a set always stay a permutation of 0..WAYS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_rank[s][w] <= c_WAY_W'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (c_WAY_W'(w) == touch_way) begin
                    r_rank[set_idx][w] <= '0;
                end else if (r_rank[set_idx][w] < w_touch_rank) begin
                    r_rank[set_idx][w] <= r_rank[set_idx][w] + c_WAY_W'(1);
                end
            end
        end
    end

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_rank[set_idx][w] == c_LAST_RANK) begin
                victim = c_WAY_W'(w);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_assoc
// Description : N-way set-associative, write-back, write-allocate data
//               cache with LRU replacement. Hits complete in the request
//               cycle; misses write back a dirty victim, refill the line
//               word by word and then complete as a hit. LINE_WORDS and SETS
//               must be at least 2.
//   clk, rst                 clock, synchronous active-high reset
//   A, WD, WE, RE            CPU request (held while ready is 0)
//   RD, ready                CPU read data / request completes this cycle
//   mem_addr, mem_wdata      backing-memory word address and write data
//   mem_we, mem_re           backing-memory write / read request
//   mem_rdata, mem_ack       backing-memory read data / word completes
//   hit_count, miss_count    saturating statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_assoc
    import data_cache_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] WD,
    input  logic              WE,
    input  logic              RE,
    output logic [DATA_W-1:0] RD,
    output logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int c_WORD_W = word_w(LINE_WORDS);
    localparam int c_IDX_W  = index_w(SETS);
    localparam int c_TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int c_WAY_W  = way_w(WAYS);
    localparam int c_OFF_W  = c_BYTE_W + c_WORD_W;
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(LINE_WORDS - 1);
    localparam logic [c_WORD_W-1:0] c_WORD0     = '0;

    state_t              r_state;
    logic                r_valid [WAYS][SETS];
    logic                r_dirty [WAYS][SETS];
    logic [c_TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [DATA_W-1:0]   r_data  [WAYS][SETS][LINE_WORDS];
    logic [c_WAY_W-1:0]  r_victim;
    logic [c_WORD_W-1:0] r_word;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                r_mem_re;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic [c_WORD_W-1:0] w_word;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_req;
    logic                w_idle;
    logic                w_hit;
    logic [c_WAY_W-1:0]  w_hit_way;
    logic                w_inv_found;
    logic [c_WAY_W-1:0]  w_inv_way;
    logic [c_WAY_W-1:0]  w_lru_way;
    logic [c_WAY_W-1:0]  w_victim;
    logic                w_victim_dirty;
    logic                w_do_hit;
    logic                w_do_miss;
    logic                w_last;
    logic [c_WORD_W-1:0] w_next_word;
    logic                w_unused;

    // Byte-within-word bits carry no information for word-aligned accesses.
    assign w_unused = &{1'b0, A[c_BYTE_W-1:0]};

    assign w_word = A[c_OFF_W-1:c_BYTE_W];
    assign w_idx  = A[c_OFF_W+c_IDX_W-1:c_OFF_W];
    assign w_tag  = A[ADDR_W-1:c_OFF_W+c_IDX_W];
    assign w_req  = WE | RE;
    assign w_idle = (r_state == IDLE);

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
        end
    end

    // Scan downward so the lowest-numbered invalid way wins.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_WAY_W'(w);
            end
        end
    end

    cache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (w_idx),
        .touch_way (w_hit_way),
        .touch_en  (w_do_hit),
        .victim    (w_lru_way)
    );

    assign w_victim       = w_inv_found ? w_inv_way : w_lru_way;
    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
    assign w_do_hit       = w_idle && w_req && w_hit;
    assign w_do_miss      = w_idle && w_req && !w_hit;
    assign w_last         = (r_word == c_LAST_WORD);
    assign w_next_word    = r_word + c_WORD_W'(1);

    assign ready      = w_idle && (!w_req || w_hit);
    assign RD         = (w_do_hit && !WE) ? r_data[w_hit_way][w_idx][w_word] : '0;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign mem_re     = r_mem_re;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Line storage carries no reset; the valid bits alone decide its meaning.
    always_ff @(posedge clk) begin
        if (w_do_hit && WE) begin
            r_data[w_hit_way][w_idx][w_word] <= WD;
        end
        if ((r_state == FILL) && mem_ack) begin
            r_data[r_victim][w_idx][r_word] <= mem_rdata;
            if (w_last) begin
                r_tag[r_victim][w_idx] <= w_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_victim    <= '0;
            r_word      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_do_hit) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                        if (WE) r_dirty[w_hit_way][w_idx] <= 1'b1;
                    end else if (w_do_miss) begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_victim <= w_victim;
                        r_word   <= '0;
                        if (w_victim_dirty) begin
                            r_state     <= WB;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_victim][w_idx], w_idx, c_WORD0, 2'b00};
                            r_mem_wdata <= r_data[w_victim][w_idx][0];
                        end else begin
                            r_state    <= FILL;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= {w_tag, w_idx, c_WORD0, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        if (w_last) begin
                            // Write request drops on the same edge the read
                            // request rises, so the two are never both high.
                            r_state    <= FILL;
                            r_mem_we   <= 1'b0;
                            r_mem_re   <= 1'b1;
                            r_word     <= '0;
                            r_mem_addr <= {w_tag, w_idx, c_WORD0, 2'b00};
                        end else begin
                            r_word      <= w_next_word;
                            r_mem_addr  <= {r_tag[r_victim][w_idx], w_idx, w_next_word, 2'b00};
                            r_mem_wdata <= r_data[r_victim][w_idx][w_next_word];
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        if (w_last) begin
                            r_state                  <= IDLE;
                            r_mem_re                 <= 1'b0;
                            r_valid[r_victim][w_idx] <= 1'b1;
                            r_dirty[r_victim][w_idx] <= 1'b0;
                        end else begin
                            r_word     <= w_next_word;
                            r_mem_addr <= {w_tag, w_idx, w_next_word, 2'b00};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache_assoc
// Description : Directed self-checking bench for data_cache_assoc. A word
//               memory model answers mem requests one word at a time and
//               logs every acknowledged transaction; expected read data and
//               expected memory traffic are queued when a request is driven
//               and compared when the cache completes it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache_assoc;

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [31:0] data;
    } xact_t;

    logic        clk;
    logic        rst;
    logic [10:0] A;
    logic [31:0] WD;
    logic        WE;
    logic        RE;
    logic [31:0] RD;
    logic        ready;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack   = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic [31:0] mem    [512];
    logic [31:0] shadow [512];
    xact_t       log_q[$];
    xact_t       exp_q[$];
    logic [31:0] rd_q[$];

    int checks   = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    data_cache_assoc #(
        .ADDR_W     (11),
        .DATA_W     (32),
        .WAYS       (2),
        .SETS       (16),
        .LINE_WORDS (4),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .WD         (WD),
        .WE         (WE),
        .RE         (RE),
        .RD         (RD),
        .ready      (ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Memory model: acknowledges a held request on the falling edge, one
    // word every second cycle, and logs what it served.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
        end else if ((mem_re || mem_we) && !mem_ack) begin
            check("mem_we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
            mem_ack = 1'b1;
            if (mem_we) begin
                mem[mem_addr[10:2]] = mem_wdata;
                log_q.push_back('{1'b1, mem_addr, mem_wdata});
            end else begin
                mem_rdata = mem[mem_addr[10:2]];
                log_q.push_back('{1'b0, mem_addr, 32'd0});
            end
        end else begin
            mem_ack = 1'b0;
        end
    end

    task automatic expect_fill(input logic [10:0] line);
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 11'(line + 4 * i), 32'd0});
    endtask

    task automatic expect_wb(input logic [10:0] line);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{1'b1, 11'(line + 4 * i), shadow[line[10:2] + 9'(i)]});
        end
    endtask

    task automatic check_mem(input string tag);
        int n;
        check({tag, "_mem_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_mem_we"}, 32'(log_q[i].we), 32'(exp_q[i].we));
            check({tag, "_mem_addr"}, 32'(log_q[i].addr), 32'(exp_q[i].addr));
            if (exp_q[i].we) check({tag, "_mem_wdata"}, log_q[i].data, exp_q[i].data);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input string tag, input logic we, input logic re,
                          input logic [10:0] a, input logic [31:0] wd, input logic exp_hit);
        int  stalls = 0;
        logic done  = 1'b0;
        if (re && !we) rd_q.push_back(shadow[a[10:2]]);
        if (we) shadow[a[10:2]] = wd;
        exp_hits++;
        if (!exp_hit) exp_miss++;
        A = a; WD = wd; WE = we; RE = re;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
            else stalls++;
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        if (done) begin
            check({tag, "_zero_wait"}, 32'(stalls == 0), 32'(exp_hit));
            if (re && !we) check({tag, "_rd"}, RD, rd_q.pop_front());
        end
        @(posedge clk); #1;
        WE = 1'b0; RE = 1'b0;
        check({tag, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
        check({tag, "_miss_count"}, 32'(miss_count), 32'(exp_miss));
        check_mem(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 32'(i * 4);
            shadow[i] = 32'(i * 4);
        end
        rst = 1'b1; A = '0; WD = '0; WE = 1'b0; RE = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_ready", 32'(ready), 32'd1);
        check("reset_rd", RD, 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_re", 32'(mem_re), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_hits", 32'(hit_count), 32'd0);
        check("reset_misses", 32'(miss_count), 32'd0);

        expect_fill(11'h000);
        access("rd000_miss", 1'b0, 1'b1, 11'h000, 32'd0, 1'b0);
        access("rd00c_hit", 1'b0, 1'b1, 11'h00C, 32'd0, 1'b1);
        expect_fill(11'h100);
        access("rd100_miss", 1'b0, 1'b1, 11'h100, 32'd0, 1'b0);
        expect_fill(11'h200);
        access("rd200_evict000", 1'b0, 1'b1, 11'h200, 32'd0, 1'b0);
        access("rd100_hit", 1'b0, 1'b1, 11'h100, 32'd0, 1'b1);
        expect_fill(11'h000);
        access("rd000_remiss", 1'b0, 1'b1, 11'h000, 32'd0, 1'b0);
        access("wr104_hit", 1'b1, 1'b0, 11'h104, 32'hDEADBEEF, 1'b1);
        expect_fill(11'h300);
        access("rd300_miss", 1'b0, 1'b1, 11'h300, 32'd0, 1'b0);
        expect_wb(11'h100);
        expect_fill(11'h200);
        access("rd200_wb", 1'b0, 1'b1, 11'h200, 32'd0, 1'b0);
        expect_fill(11'h000);
        access("wrrd008", 1'b1, 1'b1, 11'h008, 32'h12345678, 1'b0);
        access("rd008_hit", 1'b0, 1'b1, 11'h008, 32'd0, 1'b1);

        // Reset in the middle of a line fill.
        exp_q.push_back('{1'b0, 11'h400, 32'd0});
        exp_q.push_back('{1'b0, 11'h404, 32'd0});
        A = 11'h400; RE = 1'b1;
        for (int c = 0; c < 200 && log_q.size() < 2; c++) @(negedge clk);
        check("midfill_acks", 32'(log_q.size()), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1; RE = 1'b0; A = '0;
        @(posedge clk); #1;
        check("midfill_rst_mem_re", 32'(mem_re), 32'd0);
        check("midfill_rst_mem_we", 32'(mem_we), 32'd0);
        check("midfill_rst_ready", 32'(ready), 32'd1);
        check("midfill_rst_hits", 32'(hit_count), 32'd0);
        check("midfill_rst_misses", 32'(miss_count), 32'd0);
        rst = 1'b0;
        check_mem("midfill");

        // Dirty data held in the cache is lost; memory is the truth again.
        for (int i = 0; i < 512; i++) shadow[i] = mem[i];
        exp_hits = 0;
        exp_miss = 0;
        expect_fill(11'h000);
        access("post_rst_rd000", 1'b0, 1'b1, 11'h000, 32'd0, 1'b0);
        access("post_rst_rd008", 1'b0, 1'b1, 11'h008, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
